dmem_responder: RTL

//  Slave end of the core's data-memory port. Answers data_re/data_raddr reads, and commits

---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave with word RAM and an MMIO window
// (TX byte FIFO, TOHOST halt register, optional cycle counter).
// Optional feature macro: DMEM_CYCLE_CNT_EN (cycle counter present when defined).
module dmem_responder #(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_re,
  input  logic [31:0] data_raddr,
  output logic [31:0] data_rdata,
  input  logic        data_we,
  input  logic [31:0] data_waddr,
  input  logic [31:0] data_wdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] tohost
);

  localparam int unsigned RAM_WORDS = 1 << ADDR_W;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  // MMIO word offsets (addr[7:2])
  localparam logic [5:0] OFF_TXDATA = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_TOHOST = 6'h02;
  localparam logic [5:0] OFF_CYCLE  = 6'h03;

  logic [31:0]      r_mem [RAM_WORDS];
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;
  logic             r_halt;
  logic [31:0]      r_tohost;

  logic        w_rd_mmio;
  logic        w_wr_mmio;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push_req;
  logic        w_push;
  logic        w_drop;
  logic        w_stat_wr;
  logic        w_toh_wr;
  logic        w_ram_wr;
  logic [31:0] w_cycle;
  logic        w_unused;

  assign w_unused   = ^{data_raddr[1:0], data_waddr[1:0]};

  assign w_rd_mmio  = (data_raddr[31:8] == MMIO_BASE[31:8]);
  assign w_wr_mmio  = (data_waddr[31:8] == MMIO_BASE[31:8]);

  assign w_full     = (r_count == DEPTH_C);
  assign w_empty    = (r_count == '0);
  assign w_pop      = tx_valid & tx_ready;

  assign w_push_req = data_we & w_wr_mmio & (data_waddr[7:2] == OFF_TXDATA);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_stat_wr  = data_we & w_wr_mmio & (data_waddr[7:2] == OFF_STATUS);
  assign w_toh_wr   = data_we & w_wr_mmio & (data_waddr[7:2] == OFF_TOHOST);
  assign w_ram_wr   = data_we & ~w_wr_mmio & ~rst;

  assign tx_valid   = ~w_empty;
  assign tx_data    = w_empty ? '0 : r_fifo[r_rd_ptr];
  assign halt       = r_halt;
  assign tohost     = r_tohost;

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] r_cycle;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) r_cycle <= '0;
    else     r_cycle <= r_cycle + 32'd1;
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_wr) r_mem[data_waddr[ADDR_W+1:2]] <= data_wdata;
  end

  // FIFO storage write; slots need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_fifo[r_wr_ptr] <= data_wdata[7:0];
  end

  // FIFO pointers/count, overflow flag and TOHOST/halt registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_halt   <= 1'b0;
      r_tohost <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_stat_wr)   r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
      if (w_toh_wr) begin
        r_tohost <= data_wdata;
        r_halt   <= 1'b1;
      end
    end
  end

  // Zero-latency read mux; reads see pre-write state of the same cycle
  always_comb begin
    data_rdata = '0;
    if (data_re) begin
      if (w_rd_mmio) begin
        case (data_raddr[7:2])
          OFF_STATUS: data_rdata = {29'b0, r_ovf, w_full, w_empty};
          OFF_TOHOST: data_rdata = r_tohost;
          OFF_CYCLE:  data_rdata = w_cycle;
          default:    data_rdata = '0;
        endcase
      end else begin
        data_rdata = r_mem[data_raddr[ADDR_W+1:2]];
      end
    end
  end

endmodule
